// File: rtl/reg_file_ctrl_pkg.sv
// Shared constants and FSM encoding for the AVR register-file front end.
// Sizes are fixed by the AVR model: 32 byte registers organised as 16 pairs.
package reg_file_ctrl_pkg;
    localparam int ADR_W    = 5;
    localparam int RF_PAIRS = 16;
    localparam int PAIR_W   = ADR_W - 1;
    localparam logic [PAIR_W-1:0] CNT_LAST = PAIR_W'(RF_PAIRS - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;
endpackage

// File: rtl/reg_file_ctrl_if.sv
// Register-file access port: one 8/16-bit write port plus Rd/Rd16/Rr read data.
// The master drives address/write fields, the slave returns read data one cycle later.
interface reg_file_ctrl_if;
    import reg_file_ctrl_pkg::*;

    logic             rd_we;
    logic [ADR_W-1:0] rd_adr;
    logic [7:0]       rd_wdat;
    logic             rd16_we;
    logic [15:0]      rd16_wdat;
    logic [ADR_W-1:0] rr_adr;
    logic [7:0]       rd_rdat;
    logic [15:0]      rd16_rdat;
    logic [7:0]       rr_rdat;

    modport master (
        output rd_we, rd_adr, rd_wdat, rd16_we, rd16_wdat, rr_adr,
        input  rd_rdat, rd16_rdat, rr_rdat
    );

    modport slave (
        input  rd_we, rd_adr, rd_wdat, rd16_we, rd16_wdat, rr_adr,
        output rd_rdat, rd16_rdat, rr_rdat
    );
endinterface

// File: rtl/reg_file_ctrl_rf_bypass.sv
// One byte lane of write-to-read forwarding: combinational compare and select,
// zero latency, no flow control.
module rf_bypass
    import reg_file_ctrl_pkg::*;
(
    input  logic              wr_vld_i,
    input  logic [PAIR_W-1:0] wr_pair_i,
    input  logic [7:0]        wr_dat_i,
    input  logic [PAIR_W-1:0] rd_pair_i,
    input  logic [7:0]        rd_dat_i,
    output logic [7:0]        fwd_dat_o
);
    assign fwd_dat_o = (wr_vld_i && (wr_pair_i == rd_pair_i)) ? wr_dat_i : rd_dat_i;
endmodule

// File: rtl/reg_file_ctrl.sv
// Register-file front end: 16-cycle zero clear after reset, then 1-cycle read pass-through;
// busy_o stalls the core while clearing. Same-cycle forwarding is built only with RF_BYPASS_EN.
module reg_file_ctrl
    import reg_file_ctrl_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    reg_file_ctrl_if.slave  cpu,
    reg_file_ctrl_if.master rf,
    output logic            busy_o
);
    state_t            state_q;
    logic [PAIR_W-1:0] cnt_q;
    logic              busy_q;
    logic              clearing;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    cnt_q <= cnt_q + PAIR_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign clearing = (state_q == ST_CLEAR);
    assign busy_o   = busy_q;

    // Write strokes are gated by rst_i directly so the RAM is never written during reset.
    assign rf.rd_we     = ~rst_i & ~clearing & cpu.rd_we;
    assign rf.rd16_we   = ~rst_i & (clearing | cpu.rd16_we);
    assign rf.rd_adr    = clearing ? {cnt_q, 1'b0} : cpu.rd_adr;
    assign rf.rd_wdat   = clearing ? 8'h00 : cpu.rd_wdat;
    assign rf.rd16_wdat = clearing ? 16'h0000 : cpu.rd16_wdat;
    assign rf.rr_adr    = cpu.rr_adr;

    logic              lo_v, hi_v, rr_v;
    logic [7:0]        lo_w, hi_w, rr_w;
    logic [PAIR_W-1:0] wr_pair, rd_pair, rr_pair;
    logic [7:0]        fwd_lo, fwd_hi, fwd_rr, rd_byte;

`ifdef RF_BYPASS_EN
    logic             lo_v_d, hi_v_d, lo_v_q, hi_v_q;
    logic [7:0]       lo_d, hi_d, lo_q, hi_q;
    logic [PAIR_W-1:0] wr_pair_q;
    logic [ADR_W-1:0] rd_adr_q, rr_adr_q;

    // Byte enables and data mirror the RegisterFile's own write mux (16-bit wins).
    assign lo_v_d = cpu.rd16_we | (cpu.rd_we & ~cpu.rd_adr[0]);
    assign hi_v_d = cpu.rd16_we | (cpu.rd_we &  cpu.rd_adr[0]);
    assign lo_d   = cpu.rd16_we ? cpu.rd16_wdat[7:0]  : cpu.rd_wdat;
    assign hi_d   = cpu.rd16_we ? cpu.rd16_wdat[15:8] : cpu.rd_wdat;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lo_v_q    <= 1'b0;
            hi_v_q    <= 1'b0;
            lo_q      <= '0;
            hi_q      <= '0;
            wr_pair_q <= '0;
            rd_adr_q  <= '0;
            rr_adr_q  <= '0;
        end else if (clearing) begin
            lo_v_q <= 1'b0;
            hi_v_q <= 1'b0;
        end else begin
            lo_v_q    <= lo_v_d;
            hi_v_q    <= hi_v_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            wr_pair_q <= cpu.rd_adr[ADR_W-1:1];
            rd_adr_q  <= cpu.rd_adr;
            rr_adr_q  <= cpu.rr_adr;
        end
    end

    assign lo_v    = lo_v_q;
    assign hi_v    = hi_v_q;
    assign lo_w    = lo_q;
    assign hi_w    = hi_q;
    assign wr_pair = wr_pair_q;
    assign rd_pair = rd_adr_q[ADR_W-1:1];
    assign rr_pair = rr_adr_q[ADR_W-1:1];
    assign rr_v    = rr_adr_q[0] ? hi_v_q : lo_v_q;
    assign rr_w    = rr_adr_q[0] ? hi_q   : lo_q;
    assign rd_byte = rd_adr_q[0] ? fwd_hi : fwd_lo;
`else
    assign lo_v    = 1'b0;
    assign hi_v    = 1'b0;
    assign rr_v    = 1'b0;
    assign lo_w    = '0;
    assign hi_w    = '0;
    assign rr_w    = '0;
    assign wr_pair = '0;
    assign rd_pair = '0;
    assign rr_pair = '0;
    assign rd_byte = rf.rd_rdat;
`endif

    rf_bypass u_byp_lo (
        .wr_vld_i (lo_v),    .wr_pair_i (wr_pair), .wr_dat_i (lo_w),
        .rd_pair_i(rd_pair), .rd_dat_i  (rf.rd16_rdat[7:0]),  .fwd_dat_o(fwd_lo)
    );

    rf_bypass u_byp_hi (
        .wr_vld_i (hi_v),    .wr_pair_i (wr_pair), .wr_dat_i (hi_w),
        .rd_pair_i(rd_pair), .rd_dat_i  (rf.rd16_rdat[15:8]), .fwd_dat_o(fwd_hi)
    );

    rf_bypass u_byp_rr (
        .wr_vld_i (rr_v),    .wr_pair_i (wr_pair), .wr_dat_i (rr_w),
        .rd_pair_i(rr_pair), .rd_dat_i  (rf.rr_rdat),         .fwd_dat_o(fwd_rr)
    );

    // RAM contents are undefined until cleared, so reads are masked to zero meanwhile.
    assign cpu.rd_rdat   = clearing ? 8'h00    : rd_byte;
    assign cpu.rd16_rdat = clearing ? 16'h0000 : {fwd_hi, fwd_lo};
    assign cpu.rr_rdat   = clearing ? 8'h00    : fwd_rr;
endmodule

// File: tb/tb_reg_file_ctrl.sv
// Bench for reg_file_ctrl: read-first RAM model behind the DUT, architectural register
// model in front, expected reads queued at issue time and popped by an independent monitor.
module tb_reg_file_ctrl;
    import reg_file_ctrl_pkg::*;

    typedef struct packed {
        logic [7:0]  rd;
        logic [15:0] rd16;
        logic [7:0]  rr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    int   checks = 0;
    int   errors = 0;

    reg_file_ctrl_if cpu_if ();
    reg_file_ctrl_if rf_if ();

    reg_file_ctrl dut (
        .clk_i (clk),
        .rst_i (rst),
        .cpu   (cpu_if),
        .rf    (rf_if),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    // Behavioural RegisterFile: 1-cycle read-first RAM, 16-bit write wins over 8-bit.
    logic [7:0] ram [32];
    initial begin
        for (int i = 0; i < 32; i++) ram[i] <= 8'($urandom);
    end
    always @(posedge clk) begin
        rf_if.rd_rdat   <= ram[rf_if.rd_adr];
        rf_if.rd16_rdat <= {ram[{rf_if.rd_adr[4:1], 1'b1}], ram[{rf_if.rd_adr[4:1], 1'b0}]};
        rf_if.rr_rdat   <= ram[rf_if.rr_adr];
        if (rf_if.rd16_we) begin
            ram[{rf_if.rd_adr[4:1], 1'b0}] <= rf_if.rd16_wdat[7:0];
            ram[{rf_if.rd_adr[4:1], 1'b1}] <= rf_if.rd16_wdat[15:8];
        end else if (rf_if.rd_we) begin
            ram[rf_if.rd_adr] <= rf_if.rd_wdat;
        end
    end

    // Architectural register state as the core should see it.
    logic [7:0] model [32];
    exp_t       exp_q [$];
    logic       issue   = 1'b0;
    logic       issue_q = 1'b0;

    always @(posedge clk) issue_q <= issue;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (issue_q) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_underflow", 32'd0, 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("cpu_rd",   {24'd0, cpu_if.rd_rdat},   {24'd0, e.rd});
                    chk("cpu_rd16", {16'd0, cpu_if.rd16_rdat}, {16'd0, e.rd16});
                    chk("cpu_rr",   {24'd0, cpu_if.rr_rdat},   {24'd0, e.rr});
                end
            end
        end
    end

    task automatic drive(input logic we, input logic [4:0] adr, input logic [7:0] wd,
                         input logic we16, input logic [15:0] wd16, input logic [4:0] rr);
        cpu_if.rd_we     = we;
        cpu_if.rd_adr    = adr;
        cpu_if.rd_wdat   = wd;
        cpu_if.rd16_we   = we16;
        cpu_if.rd16_wdat = wd16;
        cpu_if.rr_adr    = rr;
    endtask

    // One RUN-state cycle: apply the write to the model, queue what the core must read back.
    task automatic run_cycle(input logic we, input logic [4:0] adr, input logic [7:0] wd,
                             input logic we16, input logic [15:0] wd16, input logic [4:0] rr);
        logic [7:0] snap [32];
        exp_t       e;
        drive(we, adr, wd, we16, wd16, rr);
        snap = model;
        if (we16) begin
            model[{adr[4:1], 1'b0}] = wd16[7:0];
            model[{adr[4:1], 1'b1}] = wd16[15:8];
        end else if (we) begin
            model[adr] = wd;
        end
`ifdef RF_BYPASS_EN
        snap = model;
`endif
        e.rd   = snap[adr];
        e.rd16 = {snap[{adr[4:1], 1'b1}], snap[{adr[4:1], 1'b0}]};
        e.rr   = snap[rr];
        exp_q.push_back(e);
        issue = 1'b1;
        @(negedge clk);
        issue = 1'b0;
    endtask

    // Counts busy cycles from reset release while hammering the write port; all writes must be dropped.
    task automatic clear_phase(input int expect_cycles);
        int n = 0;
        while (busy === 1'b1 && n < 40) begin
            chk("clear_rd16_zero", {16'd0, cpu_if.rd16_rdat}, 32'd0);
            chk("clear_rr_zero",   {24'd0, cpu_if.rr_rdat},   32'd0);
            if (n == 0) drive(1'b1, 5'd1, 8'h55, 1'b0, 16'h0000, 5'd1);
            else drive(1'($urandom), 5'($urandom), 8'($urandom), 1'($urandom), 16'($urandom), 5'($urandom));
            n++;
            @(negedge clk);
        end
        chk("busy_cycles", n, expect_cycles);
        for (int i = 0; i < 32; i++) model[i] = 8'h00;
        drive(1'b0, 5'd0, 8'h00, 1'b0, 16'h0000, 5'd0);
    endtask

    task automatic read_all();
        for (int i = 0; i < 32; i++)
            run_cycle(1'b0, 5'(31 - i), 8'h00, 1'b0, 16'h0000, 5'(i));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : stim
        drive(1'b1, 5'd4, 8'h77, 1'b1, 16'hFFFF, 5'd0);
        @(negedge clk);
        chk("rst_busy",    {31'd0, busy},           32'd1);
        chk("rst_rd_we",   {31'd0, rf_if.rd_we},    32'd0);
        chk("rst_rd16_we", {31'd0, rf_if.rd16_we},  32'd0);
        @(negedge clk);
        rst = 1'b0;
        clear_phase(16);
        read_all();

        run_cycle(1'b1, 5'd5,  8'hA5, 1'b0, 16'h0000, 5'd5);
        run_cycle(1'b0, 5'd25, 8'h00, 1'b1, 16'h1234, 5'd24);
        run_cycle(1'b0, 5'd25, 8'h00, 1'b0, 16'h0000, 5'd5);
        run_cycle(1'b1, 5'd2,  8'h11, 1'b1, 16'hBEEF, 5'd3);
        run_cycle(1'b0, 5'd2,  8'h00, 1'b0, 16'h0000, 5'd3);
        run_cycle(1'b0, 5'd3,  8'h00, 1'b0, 16'h0000, 5'd2);

        for (int i = 0; i < 400; i++) begin
            logic [4:0] a, r;
            a = 5'($urandom);
            r = ($urandom_range(0, 2) == 0) ? a : 5'($urandom);
            run_cycle(($urandom_range(0, 2) != 0), a, 8'($urandom),
                      ($urandom_range(0, 3) == 0), 16'($urandom), r);
        end

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            chk("midclear_busy", {31'd0, busy}, 32'd1);
            drive(1'b1, 5'($urandom), 8'($urandom), 1'b1, 16'($urandom), 5'd0);
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("midclear_rst_rd16_we", {31'd0, rf_if.rd16_we}, 32'd0);
        rst = 1'b0;
        clear_phase(16);
        read_all();

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained_end", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
